pe_feed_ctrl: RTL and testbench
===============================

PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

Interface
REQ-001 Parameters SHALL be:
  DATA_W  8   width of the signed activation and weight.
  ACC_W   32  width of the signed partial sum.
  LEN_W   8   width of the pair-count field.
  PE_LAT  1   PE clock edges from a sampled act/wgt/acc_en to the updated psum.
REQ-002 Ports SHALL be:
  clk         in   1       clock; all logic on the rising edge.
  rst_n       in   1       synchronous active-low reset.
  start       in   1       request one dot product; sampled only in IDLE.
  len         in   LEN_W   number of act/wgt pairs (K); sampled with start.
  in_valid    in   1       an input pair is available.
  in_ready    out  1       the block accepts the pair this cycle.
  in_act      in   DATA_W  signed activation.
  in_wgt      in   DATA_W  signed weight.
  pe_act      out  DATA_W  activation to the PE, registered.
  pe_wgt      out  DATA_W  weight to the PE, registered.
  pe_acc_en   out  1       PE accumulate enable, registered.
  pe_acc_clr  out  1       PE accumulator clear, registered.
  pe_psum     in   ACC_W   PE partial sum.
  res_valid   out  1       result is available.
  res_ready   in   1       downstream accepts the result.
  res_data    out  ACC_W   captured dot product, signed.
  busy        out  1       high whenever state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, OUT; only these transitions are allowed:
  IDLE -> CLEAR on start.
  CLEAR -> FEED if the latched len > 0, else CLEAR -> DRAIN.
  FEED -> DRAIN on the handshake of pair K.
  DRAIN -> OUT after PE_LAT+1 cycles.
  OUT -> IDLE on res_valid && res_ready.
REQ-004 start SHALL be ignored outside IDLE; len SHALL be latched on the edge that accepts start.
REQ-005 pe_acc_clr SHALL be 1 for exactly the one CLEAR cycle and 0 at all other times.
REQ-006 in_ready SHALL be 1 only in FEED, driven combinationally from state; a pair is accepted when in_valid && in_ready.
REQ-007 On the edge that accepts a pair, pe_act/pe_wgt SHALL load in_act/in_wgt and pe_acc_en SHALL load 1.
REQ-008 On any edge with no accepted pair, pe_acc_en SHALL load 0 and pe_act/pe_wgt SHALL load 0.
REQ-009 An LEN_W-bit pair counter SHALL count accepted pairs; acceptance stops after exactly K pairs.
REQ-010 In-flight bubbles (in_valid low) SHALL stall FEED without changing the result.
REQ-011 DRAIN SHALL last exactly PE_LAT+1 cycles; res_data SHALL capture pe_psum unmodified on the edge that ends DRAIN, and res_valid SHALL rise on that same edge.
REQ-012 With no bubbles, res_valid SHALL rise on the (len+PE_LAT+2)th rising edge after the edge that accepts start; this SHALL hold for len=0 as well.
REQ-013 In OUT, res_valid and res_data SHALL stay stable until res_ready; res_valid SHALL drop on the handshake edge.
REQ-014 A new start SHALL be accepted no earlier than the first IDLE cycle after the result handshake.
REQ-015 len=0 SHALL produce res_data = the cleared pe_psum (0), with no pe_acc_en pulse.
REQ-016 Width rule: the block SHALL NOT perform arithmetic on psum; overflow behaviour belongs to the PE.

Reset
REQ-017 When rst_n=0 at a rising edge, state SHALL go to IDLE and the pair and drain counters SHALL clear.
REQ-018 Under the same reset, pe_act, pe_wgt, pe_acc_en, pe_acc_clr, res_valid and res_data SHALL all be 0; in_ready=0 and busy=0.
REQ-019 A reset in any state, including mid-FEED or OUT, SHALL abort the operation with no res_valid pulse; the next start after reset SHALL behave normally.

Verification (bench pairs the DUT with pe_top, PE_LAT=1)
REQ-020 Reset: hold rst_n=0 for 2 edges with random inputs -> every output is 0, state is IDLE.
REQ-021 len=3 with pairs (2,3),(4,5),(1,7), in_valid held high -> res_data=33; res_valid rises 6 edges after the start edge; pe_acc_en is high for 3 consecutive cycles.
REQ-022 len=2 with pairs (-3,4),(127,-128) -> res_data=-16268.
REQ-023 len=3 with in_valid low 2 cycles between each pair -> res_data=33; pe_acc_en is 0 in each bubble cycle.
REQ-024 len=0 -> one pe_acc_clr pulse, no pe_acc_en, res_data=0, res_valid rises 3 edges after the start edge.
REQ-025 Backpressure and abort:
  res_ready held low 5 cycles with start pulsed during OUT -> res_valid/res_data stable, start ignored, busy=1.
  rst_n=0 for one edge mid-FEED -> IDLE, pe_acc_en=0, no res_valid.

Source files
------------

// File: rtl/pe_feed_ctrl.sv
// Sequencer that clears a PE accumulator, streams K act/wgt pairs into it,
// waits for the PE pipeline to settle, and then holds the final partial sum until it is taken.
module pe_feed_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8,
   parameter int PE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_act,
   input  logic [DATA_W-1:0] in_wgt,
   output logic [DATA_W-1:0] pe_act,
   output logic [DATA_W-1:0] pe_wgt,
   output logic              pe_acc_en,
   output logic              pe_acc_clr,
   input  logic [ACC_W-1:0]  pe_psum,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              busy
);

   localparam int DRN_W = $clog2(PE_LAT + 2);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  pairCnt_q, pairCnt_d;
   logic [DRN_W-1:0]  drainCnt_q, drainCnt_d;
   logic [DATA_W-1:0] peAct_q, peAct_d;
   logic [DATA_W-1:0] peWgt_q, peWgt_d;
   logic              accEn_q, accEn_d;
   logic              accClr_q, accClr_d;
   logic              resValid_q, resValid_d;
   logic [ACC_W-1:0]  resData_q, resData_d;
   logic              accept;

   assign in_ready   = (state_q == FEED);
   assign accept     = in_valid && in_ready;
   assign busy       = (state_q != IDLE);
   assign pe_act     = peAct_q;
   assign pe_wgt     = peWgt_q;
   assign pe_acc_en  = accEn_q;
   assign pe_acc_clr = accClr_q;
   assign res_valid  = resValid_q;
   assign res_data   = resData_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         pairCnt_q  <= '0;
         drainCnt_q <= '0;
         peAct_q    <= '0;
         peWgt_q    <= '0;
         accEn_q    <= 1'b0;
         accClr_q   <= 1'b0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         pairCnt_q  <= pairCnt_d;
         drainCnt_q <= drainCnt_d;
         peAct_q    <= peAct_d;
         peWgt_q    <= peWgt_d;
         accEn_q    <= accEn_d;
         accClr_q   <= accClr_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
      end
   end

   // The PE operand registers carry data only on an accepted pair, so idle cycles present zeros.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      pairCnt_d  = pairCnt_q;
      drainCnt_d = drainCnt_q;
      peAct_d    = accept ? in_act : '0;
      peWgt_d    = accept ? in_wgt : '0;
      accEn_d    = accept;
      accClr_d   = 1'b0;
      resValid_d = resValid_q;
      resData_d  = resData_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CLEAR;
               len_d    = len;
               accClr_d = 1'b1;
            end
         end
         CLEAR: begin
            pairCnt_d  = '0;
            drainCnt_d = '0;
            state_d    = (len_q != '0) ? FEED : DRAIN;
         end
         FEED: begin
            if (accept) begin
               pairCnt_d = pairCnt_q + LEN_W'(1);
               if (pairCnt_q == len_q - LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         // The last accumulate lands PE_LAT edges after its enable, so the drain waits one extra cycle.
         DRAIN: begin
            if (drainCnt_q == DRN_W'(PE_LAT)) begin
               state_d    = OUT;
               resValid_d = 1'b1;
               resData_d  = pe_psum;
            end else begin
               drainCnt_d = drainCnt_q + DRN_W'(1);
            end
         end
         OUT: begin
            if (res_ready) begin
               resValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed bench for pe_feed_ctrl: a single-cycle PE model accumulates the fed pairs,
// table vectors run full transactions, and hand sequences cover reset and abort.
module tb_pe_feed_ctrl;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [7:0]        len;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_act;
   logic [7:0]        in_wgt;
   logic [7:0]        pe_act;
   logic [7:0]        pe_wgt;
   logic              pe_acc_en;
   logic              pe_acc_clr;
   logic [31:0]       pe_psum;
   logic              res_valid;
   logic              res_ready;
   logic [31:0]       res_data;
   logic              busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         len;
      logic [3:0][7:0] act;
      logic [3:0][7:0] wgt;
      int         bubbles;
      int         hold;
      int         expRes;
      int         expLat;
   } vec_t;

   vec_t tbl[5];

   always #5 clk = ~clk;

   pe_feed_ctrl #(.DATA_W(8), .ACC_W(32), .LEN_W(8), .PE_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
      .pe_act(pe_act), .pe_wgt(pe_wgt), .pe_acc_en(pe_acc_en), .pe_acc_clr(pe_acc_clr),
      .pe_psum(pe_psum), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .busy(busy)
   );

   // Reference PE with one edge of latency from a sampled enable to the updated sum.
   logic signed [15:0] prod;
   assign prod = $signed(pe_act) * $signed(pe_wgt);
   always_ff @(posedge clk) begin
      if (!rst_n || pe_acc_clr) pe_psum <= '0;
      else if (pe_acc_en)       pe_psum <= pe_psum + 32'(prod);
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      int edges, pairIdx, bub, accCnt, clrCnt, irdyBad, accBad, stableBad, lat;
      logic expAccept, expIrdy;
      v = tbl[idx];
      @(negedge clk);
      start = 1'b1;
      len = 8'(v.len);
      in_valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      edges = -1; pairIdx = 0; bub = 0; accCnt = 0; clrCnt = 0;
      irdyBad = 0; accBad = 0; stableBad = 0; lat = -1; expAccept = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         edges++;
         if (expAccept) begin
            pairIdx++;
            bub = v.bubbles;
         end
         if (pe_acc_en !== expAccept) accBad++;
         if (pe_acc_en) accCnt++;
         if (pe_acc_clr) clrCnt++;
         expIrdy = (edges > 0) && (pairIdx < v.len);
         if (in_ready !== expIrdy) irdyBad++;
         if (res_valid) begin
            lat = edges;
            break;
         end
         if (bub > 0) begin
            in_valid = 1'b0;
            bub--;
         end else if (pairIdx < v.len) begin
            in_valid = 1'b1;
            in_act = v.act[pairIdx];
            in_wgt = v.wgt[pairIdx];
         end else begin
            in_valid = 1'b1;
            in_act = 8'h55;
            in_wgt = 8'h33;
         end
         expAccept = in_valid && expIrdy;
      end
      in_valid = 1'b0;
      if (lat < 0) begin
         checkOutput($sformatf("v%0d timeout", idx), 0, 1);
         return;
      end
      if (v.expLat > 0) checkOutput($sformatf("v%0d latency", idx), lat, v.expLat);
      checkOutput($sformatf("v%0d res_data", idx), $signed(res_data), v.expRes);
      checkOutput($sformatf("v%0d acc_en pulses", idx), accCnt, v.len);
      checkOutput($sformatf("v%0d acc_clr pulses", idx), clrCnt, 1);
      checkOutput($sformatf("v%0d acc_en timing", idx), accBad, 0);
      checkOutput($sformatf("v%0d in_ready timing", idx), irdyBad, 0);
      checkOutput($sformatf("v%0d busy in OUT", idx), busy, 1);
      for (int h = 0; h < v.hold; h++) begin
         start = (h == 1);
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (!res_valid || $signed(res_data) != v.expRes || !busy || pe_acc_clr) stableBad++;
      end
      if (v.hold > 0) checkOutput($sformatf("v%0d hold stable", idx), stableBad, 0);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d res_valid drop", idx), res_valid, 0);
      checkOutput($sformatf("v%0d busy after", idx), busy, 0);
      res_ready = 1'b0;
   endtask

   initial begin
      int seen;
      tbl[0] = '{len: 3, act: {8'd0, 8'd1, 8'd4, 8'd2}, wgt: {8'd0, 8'd7, 8'd5, 8'd3},
                 bubbles: 0, hold: 5, expRes: 33, expLat: 6};
      tbl[1] = '{len: 2, act: {8'd0, 8'd0, 8'd127, -8'sd3}, wgt: {8'd0, 8'd0, -8'sd128, 8'd4},
                 bubbles: 0, hold: 0, expRes: -16268, expLat: 5};
      tbl[2] = '{len: 3, act: {8'd0, 8'd1, 8'd4, 8'd2}, wgt: {8'd0, 8'd7, 8'd5, 8'd3},
                 bubbles: 2, hold: 0, expRes: 33, expLat: 0};
      tbl[3] = '{len: 0, act: '0, wgt: '0, bubbles: 0, hold: 0, expRes: 0, expLat: 3};
      tbl[4] = '{len: 1, act: {8'd0, 8'd0, 8'd0, -8'sd128}, wgt: {8'd0, 8'd0, 8'd0, -8'sd128},
                 bubbles: 0, hold: 1, expRes: 16384, expLat: 4};

      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_act = '0; in_wgt = '0; res_ready = 1'b0;

      // Reset with random inputs toggling.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'($urandom); len = 8'($urandom); in_valid = 1'($urandom);
         in_act = 8'($urandom); in_wgt = 8'($urandom); res_ready = 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst in_ready", in_ready, 0);
      checkOutput("rst pe_act", pe_act, 0);
      checkOutput("rst pe_wgt", pe_wgt, 0);
      checkOutput("rst acc_en", pe_acc_en, 0);
      checkOutput("rst acc_clr", pe_acc_clr, 0);
      checkOutput("rst res_valid", res_valid, 0);
      checkOutput("rst res_data", res_data, 0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;

      for (int i = 0; i < 5; i++) applyStimulus(i);

      // Abort mid-FEED after one accepted pair.
      @(negedge clk);
      start = 1'b1; len = 8'd3;
      @(posedge clk);
      #1 start = 1'b0;
      in_valid = 1'b1; in_act = 8'd5; in_wgt = 8'd5;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort pre busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort acc_en", pe_acc_en, 0);
      checkOutput("abort in_ready", in_ready, 0);
      checkOutput("abort res_valid", res_valid, 0);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid || busy || pe_acc_en) seen++;
      end
      checkOutput("abort quiet", seen, 0);
      in_valid = 1'b0;

      applyStimulus(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
